mem_access_unit: RTL

Load/store unit between the core's MEM stage and `block_ram`. Accepts one byte-addressed RISC-V load or store at a time, converts it to word-addressed `block_ram` accesses, and returns sign/zero-extended load data. Sub-word stores become read-modify-write sequences, because `block_ram` has only a whole-word `we`. Misaligned and illegal requests are rejected with an error response and never touch the RAM.

---
 rtl/mem_access_unit_pkg.sv | 25 ++
 rtl/mem_access_unit_load_align.sv | 33 +++
 rtl/mem_access_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: funct3 codes, FSM states and request legality check for the load/store unit
package mem_access_unit_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DATA,
        S_WRITE,
        S_RESP
    } state_e;

    function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        legal = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        return !legal
            || (we && (f3 == F3_BU || f3 == F3_HU))
            || ((f3 == F3_H || f3 == F3_HU) && a[0])
            || (f3 == F3_W && a != 2'b00);
    endfunction
endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: little-endian load lane extraction and sub-word store lane merge
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] dout_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    logic [31:0] lane;

    assign sh   = {addr_i, 3'b000};
    assign b    = 8'(dout_i >> sh);
    assign h    = addr_i[1] ? dout_i[31:16] : dout_i[15:0];
    assign mask = (funct3_i[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    assign lane = (funct3_i[0] ? {16'b0, wdata_i} : {24'b0, wdata_i[7:0]}) << sh;

    // Select and extend the addressed byte/halfword/word
    always_comb begin
        load_o = funct3_i == F3_B  ? {{24{b[7]}}, b}  :
                 funct3_i == F3_H  ? {{16{h[15]}}, h} :
                 funct3_i == F3_W  ? dout_i           :
                 funct3_i == F3_BU ? {24'b0, b}       :
                 funct3_i == F3_HU ? {16'b0, h}       : 32'b0;
        merge_o = (dout_i & ~mask) | (lane & mask);
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed RISC-V load/store to word-wide block_ram with read-modify-write sub-word stores
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_dout
);
    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       merged_q, merged_d;
    logic [31:0]       load_w;
    logic [31:0]       merge_w;
    logic              sw;

    load_align u_align (
        .dout_i   (ram_dout),
        .wdata_i  (wdata_q[15:0]),
        .addr_i   (addr_q[1:0]),
        .funct3_i (f3_q),
        .load_o   (load_w),
        .merge_o  (merge_w)
    );

    assign sw         = we_q && f3_q == F3_W;
    assign req_ready  = state_q == S_IDLE;
    assign resp_valid = state_q == S_RESP;
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = rdata_q;
    assign ram_addr   = 32'(addr_q[ADDR_W-1:2]);
    assign ram_en     = !rst && (state_q == S_ISSUE || state_q == S_WRITE);
    assign ram_we     = !rst && ((state_q == S_ISSUE && sw) || state_q == S_WRITE);
    assign ram_di     = state_q == S_WRITE ? merged_q :
                        (state_q == S_ISSUE && sw) ? wdata_q : 32'b0;

    // Next state: capture request in IDLE, sequence RAM read/write, one-cycle response
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        merged_d = merged_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                err_d   = req_err(req_we, req_funct3, req_addr[1:0]);
                rdata_d = 32'b0;
                state_d = err_d ? S_RESP : S_ISSUE;
            end
            S_ISSUE: state_d = sw ? S_RESP : S_DATA;
            S_DATA: begin
                merged_d = we_q ? merge_w : merged_q;
                rdata_d  = we_q ? rdata_q : load_w;
                state_d  = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b0;
            addr_q   <= '0;
            wdata_q  <= 32'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'b0;
            merged_q <= 32'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
        end
    end
endmodule
